// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and instruction memory.
// master = fetch unit (issues requests), slave = memory (returns words).
interface instr_fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemValid;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemRdata,
        input  imemValid
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemRdata,
        output imemValid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs a single-outstanding instruction-memory fetch and holds the
// current instruction for the control unit. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_unit_if.master         imem,
    input  logic                       pcSrc,
    input  logic [31:0]                pcTarget,
    input  logic                       advance,
    output logic [31:0]                pc,
    output logic [31:0]                pcPlus4,
    output logic [31:0]                instr,
    output logic                       instrValid,
    output logic [6:0]                 op,
    output logic [2:0]                 func3,
    output logic                       func7,
    output logic                       trap
);

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        StTrap  = 2'd2
`endif
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_plus4_q;
        if (pcSrc) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            pc_d = pcTarget;
`else
            pc_d = pcTarget & ~32'h3;
`endif
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_q;
    logic misaligned;
    assign misaligned = pcSrc && (pcTarget[1:0] != 2'b00);
    assign trap       = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + 32'd4;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            trap_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem.imemValid) begin
                        instr_q       <= imem.imemRdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= StHold;
                    end
                end
                StHold: begin
                    if (advance) begin
                        instr_q       <= NOP_INSTR;
                        instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            // PC keeps the address of the branch that faulted.
                            trap_q  <= 1'b1;
                            state_q <= StTrap;
                        end else begin
                            pc_q       <= pc_d;
                            pc_plus4_q <= pc_d + 32'd4;
                            state_q    <= StFetch;
                        end
`else
                        pc_q       <= pc_d;
                        pc_plus4_q <= pc_d + 32'd4;
                        state_q    <= StFetch;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                StTrap: begin
                    state_q <= StTrap;
                end
`endif
                default: state_q <= StFetch;
            endcase
        end
    end

    // Request is gated by rst_n so an in-flight fetch is dropped during reset.
    assign imem.imemReq  = rst_n && (state_q == StFetch);
    assign imem.imemAddr = pc_q;

    assign pc         = pc_q;
    assign pcPlus4    = pc_plus4_q;
    assign instr      = instr_q;
    assign instrValid = instr_valid_q;
    assign op         = instr_q[6:0];
    assign func3      = instr_q[14:12];
    assign func7      = instr_q[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] instr;
    logic        instrValid;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic        func7;
    logic        trap;

    int n_checks = 0;
    int n_pass   = 0;
    int mem_lat  = 0;
    int req_cnt  = 0;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (bus),
        .pcSrc      (pcSrc),
        .pcTarget   (pcTarget),
        .advance    (advance),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .instr      (instr),
        .instrValid (instrValid),
        .op         (op),
        .func3      (func3),
        .func7      (func7),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0293 : (a ^ 32'hC0DE_0013);
    endfunction

    // Response arrives after mem_lat full request cycles (0 = same cycle).
    assign bus.imemValid = bus.imemReq && (req_cnt >= mem_lat);
    assign bus.imemRdata = mem_word(bus.imemAddr);

    always @(posedge clk) begin
        if (bus.imemReq && !bus.imemValid) req_cnt <= req_cnt + 1;
        else                               req_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_advance(input logic src, input logic [31:0] tgt);
        @(negedge clk);
        advance  = 1'b1;
        pcSrc    = src;
        pcTarget = tgt;
        @(negedge clk);
        advance  = 1'b0;
        pcSrc    = 1'b0;
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instrValid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!instrValid) check("fetch_timeout", {31'b0, instrValid}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        advance  = 1'b0;
        pcSrc    = 1'b0;
        pcTarget = 32'h0;
        mem_lat  = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", {31'b0, bus.imemReq}, 32'd0);
        check("rst_valid", {31'b0, instrValid}, 32'd0);
        check("rst_instr", instr, Nop);
        check("rst_pc", pc, 32'h0);
        check("rst_trap", {31'b0, trap}, 32'd0);

        // First fetch, response in the request cycle
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("c1_req", {31'b0, bus.imemReq}, 32'd1);
        check("c1_addr", bus.imemAddr, 32'h0);
        @(negedge clk);
        #1;
        check("c2_valid", {31'b0, instrValid}, 32'd1);
        check("c2_op", {25'b0, op}, 32'h13);
        check("c2_func3", {29'b0, func3}, 32'd0);
        check("c2_instr", instr, 32'h0000_0293);
        check("c2_req", {31'b0, bus.imemReq}, 32'd0);
        check("c2_pcp4", pcPlus4, 32'h4);

        // Branch to 0x10
        do_advance(1'b1, 32'h10);
        check("br10_addr", bus.imemAddr, 32'h10);
        check("br10_valid", {31'b0, instrValid}, 32'd0);
        wait_valid();
        check("br10_pc", pc, 32'h10);
        check("br10_instr", instr, mem_word(32'h10));

        // Sequential advance with one cycle of memory latency
        mem_lat = 1;
        do_advance(1'b0, 32'h0);
        check("seq_addr", bus.imemAddr, 32'h14);
        check("seq_req", {31'b0, bus.imemReq}, 32'd1);
        check("seq_instr_nop", instr, Nop);
        @(negedge clk);
        #1;
        check("seq_wait_valid", {31'b0, instrValid}, 32'd0);
        check("seq_wait_instr", instr, Nop);
        wait_valid();
        check("seq_pc", pc, 32'h14);

        // Taken branch from 0x10 to 0x40
        do_advance(1'b1, 32'h10);
        wait_valid();
        do_advance(1'b1, 32'h40);
        check("br40_addr", bus.imemAddr, 32'h40);
        wait_valid();
        check("br40_instr", instr, mem_word(32'h40));

        // pcSrc without advance does nothing
        do_advance(1'b1, 32'h10);
        wait_valid();
        @(negedge clk);
        pcSrc    = 1'b1;
        pcTarget = 32'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("noadv_pc", pc, 32'h10);
            check("noadv_req", {31'b0, bus.imemReq}, 32'd0);
            check("noadv_valid", {31'b0, instrValid}, 32'd1);
        end
        pcSrc = 1'b0;

        // Reset during the second cycle of a 3-cycle-latency fetch
        mem_lat = 3;
        do_advance(1'b0, 32'h0);
        check("rstmid_addr", bus.imemAddr, 32'h14);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_req", {31'b0, bus.imemReq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid_refetch_addr", bus.imemAddr, 32'h0);
        check("rstmid_refetch_req", {31'b0, bus.imemReq}, 32'd1);
        check("rstmid_valid", {31'b0, instrValid}, 32'd0);
        wait_valid();
        check("rstmid_instr", instr, 32'h0000_0293);
        check("rstmid_pc", pc, 32'h0);

        // PC wrap-around
        mem_lat = 0;
        do_advance(1'b1, 32'hFFFF_FFFC);
        wait_valid();
        check("wrap_pcp4", pcPlus4, 32'h0);
        do_advance(1'b0, 32'h0);
        check("wrap_addr", bus.imemAddr, 32'h0);
        wait_valid();

        // Misaligned branch target
        do_advance(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_trap", {31'b0, trap}, 32'd1);
        check("mis_instr", instr, Nop);
        check("mis_pc", pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("mis_req", {31'b0, bus.imemReq}, 32'd0);
            check("mis_valid", {31'b0, instrValid}, 32'd0);
            @(negedge clk);
            #1;
        end
`else
        check("mis_addr", bus.imemAddr, 32'h40);
        check("mis_trap", {31'b0, trap}, 32'd0);
        wait_valid();
        check("mis_pc", pc, 32'h40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
